calc1_checker: RTL and testbench
================================

CALC1_CHECKER -- requirements
Module: calc1_checker

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: max cycles from operand-2 capture to response before declaring timeout.
REQ-002 c_clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_cmd_in  input  16  commands seen by calc1; port n (1..4) occupies bits [4(n-1) +: 4].
REQ-005 req_data_in  input  128  request data; port n occupies bits [32(n-1) +: 32].
REQ-006 out_resp_in  input  8  calc1 response codes; port n occupies bits [2(n-1) +: 2].
REQ-007 out_data_in  input  128  calc1 response data; port n occupies bits [32(n-1) +: 32].
REQ-008 pass_count  output  16  matched responses, all ports.
REQ-009 fail_count  output  16  mismatched or spurious responses, all ports.
REQ-010 timeout_count  output  16  responses not received within TIMEOUT_CYCLES.
REQ-011 err_valid  output  1  one-cycle pulse on any mismatch, spurious response or timeout.
REQ-012 err_port  output  2  port number minus 1 of the reported error.
REQ-013 err_expected  output  34  {expected resp[2], expected data[32]} for the reported error.

Function
REQ-014 Per-port FSM states IDLE, OP2, WAIT; single outstanding request per port.
REQ-015 IDLE: cmd != 0 -> latch cmd and data as operand 1, go OP2.
REQ-016 OP2: next cycle unconditionally latch data as operand 2, compute expected result, clear timer, go WAIT.
REQ-017 WAIT: resp != 0 -> compare, go IDLE; else timer increments; timer == TIMEOUT_CYCLES -> timeout event, go IDLE.
REQ-018 Expected ADD (1): 33-bit sum; carry set -> resp 2, else resp 1 with low 32 bits.
REQ-019 Expected SUB (2): op2 > op1 (unsigned) -> resp 2, else resp 1 with op1-op2.
REQ-020 Expected LSH (5) / RSH (6): resp 1, op1 shifted logically by op2 low 5 bits, zero fill.
REQ-021 Expected for commands 3, 4, 7-15: resp 2.
REQ-022 Match: resp equal and, only when expected resp is 1, data equal; resp 2 or 3 ignores data.
REQ-023 resp != 0 in IDLE or OP2: spurious, counted as fail, FSM state unchanged.
REQ-024 cmd != 0 in OP2 is treated as operand-2 data only; cmd != 0 in WAIT is ignored.
REQ-025 Counters update one cycle after the response/timeout cycle; increment by number of ports reporting that cycle (0-4).
REQ-026 Counters saturate at 0xFFFF; no wrap.
REQ-027 Multiple simultaneous errors: err_port reports lowest-numbered port; others still counted.
REQ-028 err_valid, err_port and err_expected are registered, same cycle as counter update; err_port and err_expected hold until next error.

Reset
REQ-029 reset asserted: all FSMs IDLE, timers 0, all counters 0, err_valid 0, err_port 0, err_expected 0, immediately.
REQ-030 reset mid-operation discards outstanding requests; no timeout or fail counted for them.

Structure
REQ-031 Shared package calc1_pkg holds CMD_NOP/ADD/SUB/LSH/RSH (0,1,2,5,6) and RESP_NONE/OK/ERR/INTERNAL (0..3).
REQ-032 Sub-module calc1_port_checker holds one port's FSM, timer and expected-result logic; instantiated 4 times; top holds counters and error select.

Verification
REQ-033 Port 1: ADD 0xFFFF0000, 0x0000FFFF; resp 1 data 0xFFFFFFFF 3 cycles later -> pass_count 1, err_valid 0.
REQ-034 Port 2: ADD 0xFFFFFFFF, 0x00000001; DUT returns resp 1 data 0 -> fail_count 1, err_port 1, err_expected {2, 0}.
REQ-035 Port 3: SUB 5, 6; resp 2 -> pass_count 1; repeat with resp 1 data 0xFFFFFFFF -> fail_count 1.
REQ-036 Port 4: LSH 0x00000001, 0x00000024; resp 1 data 0x00000010 -> pass.
REQ-037 Port 1 ADD, no response for 16 cycles -> timeout_count 1, err_valid pulse, err_port 0; later resp -> fail_count 1 (spurious).
REQ-038 All 4 ports match in same cycle -> pass_count +4 in one update; reset asserted in WAIT then response -> counters 0 then fail_count 1.

Source files
------------

// File: rtl/calc1_pkg.sv
// Shared constants, types and the expected-result helpers used by the
// calc1 response checker.
package calc1_pkg;

   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_LSH = 4'd5;
   localparam logic [3:0] CMD_RSH = 4'd6;

   localparam logic [1:0] RESP_NONE     = 2'd0;
   localparam logic [1:0] RESP_OK       = 2'd1;
   localparam logic [1:0] RESP_ERR      = 2'd2;
   localparam logic [1:0] RESP_INTERNAL = 2'd3;

   localparam int NUM_PORTS = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OP2  = 2'd1,
      ST_WAIT = 2'd2
   } port_state_e;

   // Expected response; packs to {resp, data} (34 bits).
   typedef struct packed {
      logic [1:0]  resp;
      logic [31:0] data;
   } exp_t;

   // Reference result of one calc1 command. Data is zero when resp is not OK.
   function automatic exp_t calc_expected(input logic [3:0] cmd,
                                          input logic [31:0] op1,
                                          input logic [31:0] op2);
      exp_t        res;
      logic [32:0] sum;
      res.resp = RESP_ERR;
      res.data = 32'h0000_0000;
      sum      = 33'h0_0000_0000;
      case (cmd)
         CMD_ADD: begin
            sum = {1'b0, op1} + {1'b0, op2};
            if (sum[32]) begin
               res.resp = RESP_ERR;
            end else begin
               res.resp = RESP_OK;
               res.data = sum[31:0];
            end
         end
         CMD_SUB: begin
            if (op2 > op1) begin
               res.resp = RESP_ERR;
            end else begin
               res.resp = RESP_OK;
               res.data = op1 - op2;
            end
         end
         CMD_LSH: begin
            res.resp = RESP_OK;
            res.data = op1 << op2[4:0];
         end
         CMD_RSH: begin
            res.resp = RESP_OK;
            res.data = op1 >> op2[4:0];
         end
         default: begin
            res.resp = RESP_ERR;
         end
      endcase
      return res;
   endfunction

   // Counter add that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_add(input logic [15:0] cnt,
                                           input logic [2:0]  inc);
      logic [16:0] sum;
      sum = {1'b0, cnt} + {14'h0000, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/calc1_port_checker.sv
// One port's request tracker: captures two operands, predicts the calc1
// result and classifies the response (or its absence) in the same cycle.
module calc1_port_checker
   import calc1_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  cmd,
   input  logic [31:0] data,
   input  logic [1:0]  resp,
   input  logic [31:0] rdata,
   output logic        pass_evt,
   output logic        fail_evt,
   output logic        timeout_evt,
   output logic [33:0] err_expected
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   port_state_e   state_r;
   logic [3:0]    cmd_r;
   logic [31:0]   op1_r;
   exp_t          exp_r;
   logic [TW-1:0] timer_r;
   logic          timer_done_s;
   logic          match_s;

   assign timer_done_s = (timer_r == TW'(TIMEOUT_CYCLES));

   // Request FSM: operand capture, expected-result latch and response timer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cmd_r   <= CMD_NOP;
         op1_r   <= 32'h0000_0000;
         exp_r   <= '0;
         timer_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (cmd != CMD_NOP) begin
                  cmd_r   <= cmd;
                  op1_r   <= data;
                  state_r <= ST_OP2;
               end
            end
            ST_OP2: begin
               // Any cmd seen here is ignored; only the data is operand 2.
               exp_r   <= calc_expected(cmd_r, op1_r, data);
               timer_r <= '0;
               state_r <= ST_WAIT;
            end
            ST_WAIT: begin
               if (resp != RESP_NONE) begin
                  state_r <= ST_IDLE;
               end else if (timer_done_s) begin
                  state_r <= ST_IDLE;
               end else begin
                  timer_r <= timer_r + TW'(1);
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Classify this cycle's response against the outstanding expectation.
   always_comb begin
      pass_evt     = 1'b0;
      fail_evt     = 1'b0;
      timeout_evt  = 1'b0;
      err_expected = 34'h0_0000_0000;
      match_s      = (resp == exp_r.resp) &&
                     ((exp_r.resp != RESP_OK) || (rdata == exp_r.data));
      case (state_r)
         ST_WAIT: begin
            err_expected = exp_r;
            if (resp != RESP_NONE) begin
               if (match_s) begin
                  pass_evt = 1'b1;
               end else begin
                  fail_evt = 1'b1;
               end
            end else if (timer_done_s) begin
               timeout_evt = 1'b1;
            end else begin
               timeout_evt = 1'b0;
            end
         end
         default: begin
            // A response with nothing outstanding is spurious.
            if (resp != RESP_NONE) begin
               fail_evt = 1'b1;
            end else begin
               fail_evt = 1'b0;
            end
         end
      endcase
   end

endmodule

// File: rtl/calc1_checker.sv
// Four-port calc1 response checker: per-port trackers plus shared
// saturating counters and lowest-port error reporting.
module calc1_checker
   import calc1_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic         c_clk,
   input  logic         reset,
   input  logic [15:0]  req_cmd_in,
   input  logic [127:0] req_data_in,
   input  logic [7:0]   out_resp_in,
   input  logic [127:0] out_data_in,
   output logic [15:0]  pass_count,
   output logic [15:0]  fail_count,
   output logic [15:0]  timeout_count,
   output logic         err_valid,
   output logic [1:0]   err_port,
   output logic [33:0]  err_expected
);

   logic [NUM_PORTS-1:0] pass_s;
   logic [NUM_PORTS-1:0] fail_s;
   logic [NUM_PORTS-1:0] to_s;
   logic [33:0]          exp_s [NUM_PORTS];
   logic [2:0]           pass_inc_s;
   logic [2:0]           fail_inc_s;
   logic [2:0]           to_inc_s;
   logic                 err_any_s;
   logic [1:0]           err_sel_s;
   logic [33:0]          err_exp_sel_s;

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      calc1_port_checker #(
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_port (
         .clk          (c_clk),
         .reset        (reset),
         .cmd          (req_cmd_in[4*g +: 4]),
         .data         (req_data_in[32*g +: 32]),
         .resp         (out_resp_in[2*g +: 2]),
         .rdata        (out_data_in[32*g +: 32]),
         .pass_evt     (pass_s[g]),
         .fail_evt     (fail_s[g]),
         .timeout_evt  (to_s[g]),
         .err_expected (exp_s[g])
      );
   end

   // Per-cycle event totals and lowest-numbered erroring port.
   always_comb begin
      pass_inc_s    = 3'd0;
      fail_inc_s    = 3'd0;
      to_inc_s      = 3'd0;
      err_any_s     = 1'b0;
      err_sel_s     = 2'd0;
      err_exp_sel_s = 34'h0_0000_0000;
      for (int i = 0; i < NUM_PORTS; i++) begin
         pass_inc_s = pass_inc_s + {2'b00, pass_s[i]};
         fail_inc_s = fail_inc_s + {2'b00, fail_s[i]};
         to_inc_s   = to_inc_s + {2'b00, to_s[i]};
      end
      // Walk downwards so the lowest-numbered port is the last writer.
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (fail_s[i] || to_s[i]) begin
            err_any_s     = 1'b1;
            err_sel_s     = 2'(i);
            err_exp_sel_s = exp_s[i];
         end else begin
            err_any_s     = err_any_s;
         end
      end
   end

   // Registered counters and error report; report fields hold between errors.
   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         pass_count    <= 16'h0000;
         fail_count    <= 16'h0000;
         timeout_count <= 16'h0000;
         err_valid     <= 1'b0;
         err_port      <= 2'd0;
         err_expected  <= 34'h0_0000_0000;
      end else begin
         pass_count    <= sat_add(pass_count, pass_inc_s);
         fail_count    <= sat_add(fail_count, fail_inc_s);
         timeout_count <= sat_add(timeout_count, to_inc_s);
         err_valid     <= err_any_s;
         if (err_any_s) begin
            err_port     <= err_sel_s;
            err_expected <= err_exp_sel_s;
         end
      end
   end

endmodule

// File: tb/tb_calc1_checker.sv
// Directed self-checking bench for calc1_checker.
module tb_calc1_checker;

   logic         c_clk;
   logic         reset;
   logic [15:0]  req_cmd_in;
   logic [127:0] req_data_in;
   logic [7:0]   out_resp_in;
   logic [127:0] out_data_in;
   logic [15:0]  pass_count;
   logic [15:0]  fail_count;
   logic [15:0]  timeout_count;
   logic         err_valid;
   logic [1:0]   err_port;
   logic [33:0]  err_expected;

   int checks   = 0;
   int failures = 0;
   int exp_pass = 0;
   int exp_fail = 0;
   int exp_to   = 0;

   calc1_checker #(.TIMEOUT_CYCLES(16)) dut (
      .c_clk         (c_clk),
      .reset         (reset),
      .req_cmd_in    (req_cmd_in),
      .req_data_in   (req_data_in),
      .out_resp_in   (out_resp_in),
      .out_data_in   (out_data_in),
      .pass_count    (pass_count),
      .fail_count    (fail_count),
      .timeout_count (timeout_count),
      .err_valid     (err_valid),
      .err_port      (err_port),
      .err_expected  (err_expected)
   );

   initial c_clk = 1'b0;
   always #5 c_clk = ~c_clk;

   task automatic tick();
      @(posedge c_clk);
      #1;
   endtask

   // Two-cycle request: cmd + operand 1, then operand 2. Leaves FSM in WAIT.
   task automatic issue(input int p, input logic [3:0] cmd,
                        input logic [31:0] op1, input logic [31:0] op2);
      req_cmd_in[4*p +: 4]    = cmd;
      req_data_in[32*p +: 32] = op1;
      tick();
      req_cmd_in[4*p +: 4]    = 4'd0;
      req_data_in[32*p +: 32] = op2;
      tick();
      req_data_in[32*p +: 32] = 32'h0;
   endtask

   task automatic respond(input int p, input logic [1:0] r, input logic [31:0] d);
      out_resp_in[2*p +: 2]   = r;
      out_data_in[32*p +: 32] = d;
      tick();
      out_resp_in[2*p +: 2]   = 2'd0;
      out_data_in[32*p +: 32] = 32'h0;
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      req_cmd_in  = 16'h0;
      req_data_in = 128'h0;
      out_resp_in = 8'h0;
      out_data_in = 128'h0;
      tick();
      tick();
      checks++;
      if (pass_count !== 16'h0 || fail_count !== 16'h0 || timeout_count !== 16'h0) begin
         failures++;
         $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", pass_count, fail_count, timeout_count);
      end
      checks++;
      if (err_valid !== 1'b0 || err_port !== 2'd0 || err_expected !== 34'h0) begin
         failures++;
         $display("FAIL reset_err got %b/%0d/%h want 0/0/0", err_valid, err_port, err_expected);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_add_pass();
      issue(0, 4'd1, 32'hFFFF0000, 32'h0000FFFF);
      respond(0, 2'd1, 32'hFFFFFFFF);
      exp_pass++;
      checks++;
      if (pass_count !== 16'(exp_pass) || fail_count !== 16'(exp_fail)) begin
         failures++;
         $display("FAIL add_pass got pass=%0d fail=%0d want %0d/%0d", pass_count, fail_count, exp_pass, exp_fail);
      end
      checks++;
      if (err_valid !== 1'b0) begin
         failures++;
         $display("FAIL add_pass_errvalid got %b want 0", err_valid);
      end
   endtask

   task automatic test_add_overflow();
      issue(1, 4'd1, 32'hFFFFFFFF, 32'h00000001);
      respond(1, 2'd1, 32'h0);
      exp_fail++;
      checks++;
      if (fail_count !== 16'(exp_fail) || err_valid !== 1'b1) begin
         failures++;
         $display("FAIL add_ovf got fail=%0d ev=%b want %0d/1", fail_count, err_valid, exp_fail);
      end
      checks++;
      if (err_port !== 2'd1 || err_expected !== {2'd2, 32'h0}) begin
         failures++;
         $display("FAIL add_ovf_report got port=%0d exp=%h want 1/%h", err_port, err_expected, {2'd2, 32'h0});
      end
      tick();
      checks++;
      if (err_valid !== 1'b0 || err_port !== 2'd1) begin
         failures++;
         $display("FAIL err_hold got ev=%b port=%0d want 0/1", err_valid, err_port);
      end
   endtask

   task automatic test_sub();
      issue(2, 4'd2, 32'd5, 32'd6);
      respond(2, 2'd2, 32'h1234);
      exp_pass++;
      checks++;
      if (pass_count !== 16'(exp_pass) || err_valid !== 1'b0) begin
         failures++;
         $display("FAIL sub_borrow_pass got pass=%0d ev=%b want %0d/0", pass_count, err_valid, exp_pass);
      end
      issue(2, 4'd2, 32'd5, 32'd6);
      respond(2, 2'd1, 32'hFFFFFFFF);
      exp_fail++;
      checks++;
      if (fail_count !== 16'(exp_fail) || err_port !== 2'd2 || err_expected !== {2'd2, 32'h0}) begin
         failures++;
         $display("FAIL sub_borrow_fail got fail=%0d port=%0d exp=%h want %0d/2/%h",
                  fail_count, err_port, err_expected, exp_fail, {2'd2, 32'h0});
      end
   endtask

   task automatic test_shift();
      issue(3, 4'd5, 32'h00000001, 32'h00000024);
      respond(3, 2'd1, 32'h00000010);
      exp_pass++;
      checks++;
      if (pass_count !== 16'(exp_pass) || err_valid !== 1'b0) begin
         failures++;
         $display("FAIL lsh got pass=%0d ev=%b want %0d/0", pass_count, err_valid, exp_pass);
      end
      issue(3, 4'd6, 32'h80000000, 32'h0000001F);
      respond(3, 2'd1, 32'h00000001);
      exp_pass++;
      checks++;
      if (pass_count !== 16'(exp_pass)) begin
         failures++;
         $display("FAIL rsh got pass=%0d want %0d", pass_count, exp_pass);
      end
      issue(3, 4'd7, 32'h1, 32'h1);
      respond(3, 2'd3, 32'h0);
      checks++;
      if (fail_count !== 16'(exp_fail + 1) || err_port !== 2'd3 || err_expected !== {2'd2, 32'h0}) begin
         failures++;
         $display("FAIL illegal_cmd got fail=%0d port=%0d exp=%h want %0d/3/%h",
                  fail_count, err_port, err_expected, exp_fail + 1, {2'd2, 32'h0});
      end
      exp_fail++;
   endtask

   task automatic test_data_mismatch();
      issue(0, 4'd1, 32'h10, 32'h20);
      respond(0, 2'd1, 32'h31);
      exp_fail++;
      checks++;
      if (fail_count !== 16'(exp_fail) || err_port !== 2'd0 || err_expected !== {2'd1, 32'h30}) begin
         failures++;
         $display("FAIL data_mismatch got fail=%0d port=%0d exp=%h want %0d/0/%h",
                  fail_count, err_port, err_expected, exp_fail, {2'd1, 32'h30});
      end
   endtask

   task automatic test_timeout();
      issue(0, 4'd1, 32'd1, 32'd2);
      repeat (16) tick();
      checks++;
      if (timeout_count !== 16'(exp_to) || err_valid !== 1'b0) begin
         failures++;
         $display("FAIL timeout_early got to=%0d ev=%b want %0d/0", timeout_count, err_valid, exp_to);
      end
      tick();
      exp_to++;
      checks++;
      if (timeout_count !== 16'(exp_to) || err_valid !== 1'b1 || err_port !== 2'd0 ||
          err_expected !== {2'd1, 32'd3}) begin
         failures++;
         $display("FAIL timeout got to=%0d ev=%b port=%0d exp=%h want %0d/1/0/%h",
                  timeout_count, err_valid, err_port, err_expected, exp_to, {2'd1, 32'd3});
      end
      tick();
      respond(0, 2'd1, 32'd3);
      exp_fail++;
      checks++;
      if (fail_count !== 16'(exp_fail) || err_valid !== 1'b1 || err_expected !== 34'h0) begin
         failures++;
         $display("FAIL late_resp got fail=%0d ev=%b exp=%h want %0d/1/0",
                  fail_count, err_valid, err_expected, exp_fail);
      end
   endtask

   task automatic test_multi_spurious();
      out_resp_in = 8'b01_11_00_00;
      tick();
      out_resp_in = 8'h0;
      exp_fail += 2;
      checks++;
      if (fail_count !== 16'(exp_fail) || err_port !== 2'd2 || err_expected !== 34'h0) begin
         failures++;
         $display("FAIL multi_spurious got fail=%0d port=%0d exp=%h want %0d/2/0",
                  fail_count, err_port, err_expected, exp_fail);
      end
   endtask

   task automatic test_back_to_back();
      req_cmd_in  = {4'd6, 4'd5, 4'd2, 4'd1};
      req_data_in = {32'h000000F0, 32'h0000000F, 32'h00000010, 32'h7FFFFFFF};
      tick();
      req_cmd_in  = {4'd1, 4'd1, 4'd1, 4'd1};
      req_data_in = {32'd4, 32'd4, 32'h00000010, 32'd1};
      tick();
      req_cmd_in  = 16'h0;
      req_data_in = 128'h0;
      out_resp_in = 8'b01_01_01_01;
      out_data_in = {32'h0000000F, 32'h000000F0, 32'h0, 32'h80000000};
      tick();
      out_resp_in = 8'h0;
      out_data_in = 128'h0;
      exp_pass += 4;
      checks++;
      if (pass_count !== 16'(exp_pass) || fail_count !== 16'(exp_fail) || err_valid !== 1'b0) begin
         failures++;
         $display("FAIL all_ports got pass=%0d fail=%0d ev=%b want %0d/%0d/0",
                  pass_count, fail_count, err_valid, exp_pass, exp_fail);
      end
      issue(0, 4'd2, 32'd9, 32'd4);
      respond(0, 2'd1, 32'd5);
      exp_pass++;
      checks++;
      if (pass_count !== 16'(exp_pass)) begin
         failures++;
         $display("FAIL back_to_back got pass=%0d want %0d", pass_count, exp_pass);
      end
   endtask

   task automatic test_reset_mid();
      issue(1, 4'd1, 32'd1, 32'd1);
      reset = 1'b1;
      #1;
      checks++;
      if (pass_count !== 16'h0 || fail_count !== 16'h0 || timeout_count !== 16'h0 || err_valid !== 1'b0) begin
         failures++;
         $display("FAIL async_reset got %0d/%0d/%0d ev=%b want 0/0/0/0",
                  pass_count, fail_count, timeout_count, err_valid);
      end
      tick();
      reset    = 1'b0;
      exp_pass = 0;
      exp_fail = 0;
      exp_to   = 0;
      repeat (20) tick();
      checks++;
      if (timeout_count !== 16'h0 || fail_count !== 16'h0) begin
         failures++;
         $display("FAIL reset_discard got to=%0d fail=%0d want 0/0", timeout_count, fail_count);
      end
      respond(1, 2'd1, 32'd2);
      exp_fail++;
      checks++;
      if (fail_count !== 16'(exp_fail) || pass_count !== 16'h0 || err_port !== 2'd1) begin
         failures++;
         $display("FAIL reset_spurious got fail=%0d pass=%0d port=%0d want %0d/0/1",
                  fail_count, pass_count, err_port, exp_fail);
      end
   endtask

   task automatic test_saturation();
      out_resp_in = 8'hFF;
      repeat (16384) tick();
      out_resp_in = 8'h0;
      checks++;
      if (fail_count !== 16'hFFFF || pass_count !== 16'h0 || err_port !== 2'd0) begin
         failures++;
         $display("FAIL saturation got fail=%h pass=%0d port=%0d want ffff/0/0",
                  fail_count, pass_count, err_port);
      end
      tick();
      checks++;
      if (fail_count !== 16'hFFFF || err_valid !== 1'b0) begin
         failures++;
         $display("FAIL saturation_hold got fail=%h ev=%b want ffff/0", fail_count, err_valid);
      end
   endtask

   initial begin
      test_reset();
      test_add_pass();
      test_add_overflow();
      test_sub();
      test_shift();
      test_data_mismatch();
      test_timeout();
      test_multi_spurious();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
